bus_rr_scheduler: RTL
=====================

// Module: bus_rr_scheduler
// PURPOSE
// - Sequences the shared packet bus between `drvrs` device FIFOs: round-robin grant, pop one packet, route it.
// - Sits between the per-device FIFO/driver side (pndng/pop/D_pop) and the receive side (push/D_push).
// - Destination decode: dest ID = packet[pckg_sz-1 -: 8]; dest == broadcast goes to every device except the source.
// - Moves one packet per 3-cycle transaction; no internal queueing beyond one packet register.
// PARAMETERS
// - drvrs      4      number of devices (2..255)
// - pckg_sz    16     packet width in bits; must be >= 9 (8-bit ID + payload)
// - broadcast  8'hFF  destination ID meaning "all devices except source"
// PORTS
// - clk        in   1                single clock, rising edge
// - reset      in   1                asynchronous, active-high; clears all state
// - pndng      in   drvrs            device i FIFO non-empty; D_pop[i] valid while high (first-word fall-through)
// - D_pop      in   drvrs x pckg_sz  head-of-FIFO packet per device
// - pop        out  drvrs            one-hot, 1-cycle pulse; dequeues granted FIFO
// - push       out  drvrs            destination strobe(s), 1-cycle pulse
// - D_push     out  pckg_sz          packet on bus; valid while any push bit high
// - drop       out  1                1-cycle pulse: packet discarded (bad dest or dest == source)
// BEHAVIOUR
// - Reset values: pop=0, push=0, D_push=0, drop=0, state=IDLE, rr pointer=drvrs-1 (device 0 wins first).
// - All outputs are registered. FSM states: IDLE, POP, PUSH.
// - IDLE: if |pndng, choose the first requester at index (ptr+1) mod drvrs upward, with wrap-around.
//   - Next edge: grant<=g, ptr<=g, pkt<=D_pop[g], pop<=onehot(g), state<=POP.
//   - If no requests: remain in IDLE with all outputs 0.
// - POP: next edge: pop<=0, D_push<=pkt, state<=PUSH.
//   - dest==broadcast: push<=~onehot(grant).
//   - dest<drvrs and dest!=grant: push<=onehot(dest).
//   - otherwise: push<=0 and drop<=1.
// - PUSH: next edge: push<=0, drop<=0, state<=IDLE. D_push holds its last value.
// - Latency: pndng high in IDLE at edge N -> pop high N..N+1 -> push high N+1..N+2.
// - Next grant is evaluated no earlier than IDLE after PUSH.
// - pndng/D_pop changes during POP or PUSH are ignored; the packet is already latched.
// - Fairness: a requester waits at most drvrs-1 transactions. Sole requester is re-granted back-to-back.
// - Reset asserted mid-transaction: in-flight packet is lost, no push issued, outputs clear immediately (async).
// CONFIGURATION
// - BUS_SCHED_STATS_EN defined: adds output pkt_cnt[31:0] and output drop_cnt[15:0].
//   - pkt_cnt +1 per PUSH with push!=0; drop_cnt +1 per drop pulse.
//   - Both saturate at all-ones and reset to 0.
// - BUS_SCHED_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
// - Package bus_sched_pkg: ID_W=8; typedef enum logic[1:0] {IDLE,POP,PUSH} sched_state_t;
//   function dest_of(pkt) returning the 8-bit dest ID.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs gnt_idx and any_req. Combinational priority rotate.
// - Top module holds the FSM, packet register, routing decode and optional stats counters.
// TESTING (drvrs=4, pckg_sz=16, broadcast=8'hFF)
// - Single unicast: pndng=4'b0001, D_pop[0]=16'h02AB
//   -> pop=0001 for 1 cycle; next cycle push=0100, D_push=16'h02AB; drop=0.
// - Broadcast: pndng=4'b0100, D_pop[2]=16'hFF55 -> push=1011, D_push=16'hFF55.
// - Round-robin: pndng=4'b1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again.
//   - Each source pops exactly once per 12 cycles.
// - Invalid destinations -> drop=1, push=0000, next grant proceeds normally:
//   - D_pop[1]=16'h07CC (dest 7 >= drvrs).
//   - D_pop[1]=16'h01CC (dest == source).
// - Reset during POP: assert reset 2ns after pop rises
//   -> pop=0 immediately; no push ever appears; after release device 0 has priority.
// - With BUS_SCHED_STATS_EN: run 3 valid packets + 1 drop -> pkt_cnt=3, drop_cnt=1.

Source files
------------

// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for the bus round-robin scheduler.
//   sched_state_t : transaction phase (IDLE -> POP -> PUSH)
//   dest_of()     : extracts the 8-bit destination ID from a packet's top byte
package bus_sched_pkg;

    localparam int ID_W      = 8;
    // Widest packet dest_of() can decode; callers zero-extend into this width.
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } sched_state_t;

    // pkt_w is the real packet width; the ID is the top ID_W bits of that width.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int                   pkt_w);
        logic [PKT_MAX_W-1:0] shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Device-side bus bundle for bus_rr_scheduler.
//   pndng  : per-device FIFO non-empty
//   D_pop  : per-device head-of-FIFO packet (first-word fall-through)
//   pop    : one-hot dequeue pulse to the granted FIFO
//   push   : destination strobe(s)
//   D_push : packet on the shared bus, valid while any push bit is high
//   drop   : packet discarded (bad destination or destination == source)
// master = scheduler side, slave = device/FIFO side.
interface bus_rr_scheduler_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0]              push;
    logic [pckg_sz-1:0]            D_push;
    logic                          drop;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, drop
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, drop
    );
endinterface

// File: rtl/bus_rr_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   gnt_idx : index of the winning requester (0 when no request)
//   any_req : at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          any_req
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for a shared packet bus between drvrs device FIFOs.
// Grants one requester, pops its head packet, then routes it to the decoded
// destination (or all others on broadcast); one packet per 3-cycle transaction.
//   clk, reset         : clock; asynchronous active-high reset
//   bus (master)       : pndng/D_pop in, pop/push/D_push/drop out (all registered)
//   pkt_cnt, drop_cnt  : only when BUS_SCHED_STATS_EN is defined; saturating
//                        counts of delivered and dropped packets
//
// state | meaning
// IDLE  | waiting for any pndng; grants and latches the packet on the next edge
// POP   | pop pulse out; routing decode of the latched packet
// PUSH  | push/drop pulse out; returns to IDLE
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    bus_rr_scheduler_if.master  bus
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [31:0]         pkt_cnt,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int               PW  = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    sched_state_t       state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      grant_q;
    logic [pckg_sz-1:0] pkt_q;

    logic [PW-1:0]      gnt_idx;
    logic               any_req;
    logic [ID_W-1:0]    dest;
    logic [drvrs-1:0]   route;
    logic               bad_dest;

    rr_arbiter #(.N(drvrs), .PW(PW)) u_arb (
        .req     (bus.pndng),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign dest = dest_of(PKT_MAX_W'(pkt_q), pckg_sz);

    // Broadcast never loops back to the source; unicast to self is a drop.
    always_comb begin
        route    = '0;
        bad_dest = 1'b0;
        if (dest == broadcast) begin
            route = ~(ONE << grant_q);
        end else if (int'(dest) < drvrs && int'(dest) != int'(grant_q)) begin
            route = ONE << dest;
        end else begin
            bad_dest = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(drvrs - 1);
            grant_q    <= '0;
            pkt_q      <= '0;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.D_push <= '0;
            bus.drop   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= gnt_idx;
                        ptr_q   <= gnt_idx;
                        pkt_q   <= bus.D_pop[gnt_idx];
                        bus.pop <= ONE << gnt_idx;
                        state_q <= POP;
                    end
                end
                POP: begin
                    bus.pop    <= '0;
                    bus.D_push <= pkt_q;
                    bus.push   <= route;
                    bus.drop   <= bad_dest;
                    state_q    <= PUSH;
                end
                PUSH: begin
                    bus.push <= '0;
                    bus.drop <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BUS_SCHED_STATS_EN
    // push/drop are only ever non-zero while in PUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (|bus.push && pkt_cnt != '1) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (bus.drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
